// File: rtl/mwc_pkg.sv
// rtl/mwc_pkg.sv - shared types and constants for the memory write checker
package mwc_pkg;

    typedef enum logic [1:0] {
        MWC_IDLE      = 2'd0,
        MWC_ARMED     = 2'd1,
        MWC_DONE_PASS = 2'd2,
        MWC_DONE_FAIL = 2'd3
    } mwc_state_t;

    localparam int DEFAULT_ADDR_WIDTH     = 32;
    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_NUM_CHECKS     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 0;
    localparam int DEFAULT_COUNT_WIDTH    = 16;

    typedef struct packed {
        logic                          enable;
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } mwc_entry_t;

    // Index fields stay at least one bit wide even for a single-entry table.
    function automatic int mwc_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mwc_entry.sv
// rtl/mwc_entry.sv - one expected-store table entry with sticky pass/fail status
module mwc_entry #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we_i,
    input  logic [ADDR_WIDTH-1:0] cfg_addr_i,
    input  logic [DATA_WIDTH-1:0] cfg_data_i,
    input  logic                  cfg_enable_i,
    input  logic                  arm_clr_i,
    input  logic                  store_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic                  enable_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic                  pass_next_o,
    output logic                  fail_next_o,
    output logic                  miss_o
);

    logic                  enable_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  pass_q;
    logic                  fail_q;
    logic                  hit;
    logic                  match;

    // Case equality makes X/Z on the bus count as a mismatch in simulation.
    assign hit         = store_i && enable_q && (mem_addr_i === addr_q);
    assign match       = hit && (mem_wdata_i === data_q);
    assign miss_o      = hit && !(mem_wdata_i === data_q);
    assign fail_next_o = fail_q | miss_o;
    assign pass_next_o = (pass_q | match) & ~fail_next_o;

    assign enable_o = enable_q;
    assign pass_o   = pass_q;
    assign fail_o   = fail_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                enable_q <= cfg_enable_i;
                addr_q   <= cfg_addr_i;
                data_q   <= cfg_data_i;
            end
            if (arm_clr_i) begin
                pass_q <= 1'b0;
                fail_q <= 1'b0;
            end else if (store_i) begin
                pass_q <= pass_next_o;
                fail_q <= fail_next_o;
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - programmable store-table self-test monitor driving success/fail pins
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int NUM_CHECKS     = DEFAULT_NUM_CHECKS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cfg_we,
    input  logic [mwc_idx_width(NUM_CHECKS)-1:0] cfg_idx,
    input  logic [ADDR_WIDTH-1:0]                cfg_addr,
    input  logic [DATA_WIDTH-1:0]                cfg_data,
    input  logic                                 cfg_enable,
    input  logic                                 arm,
    input  logic                                 clear,
    input  logic                                 mem_write,
    input  logic [ADDR_WIDTH-1:0]                mem_addr,
    input  logic [DATA_WIDTH-1:0]                mem_wdata,
    output logic                                 busy,
    output logic                                 success,
    output logic                                 fail,
    output logic                                 timed_out,
    output logic [NUM_CHECKS-1:0]                pass_mask,
    output logic [NUM_CHECKS-1:0]                fail_mask,
    output logic [mwc_idx_width(NUM_CHECKS)-1:0] first_fail_idx,
    output logic [COUNT_WIDTH-1:0]               store_count
);

    localparam int IW = mwc_idx_width(NUM_CHECKS);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    mwc_state_t        state_q;
    logic              timed_out_q;
    logic [IW-1:0]     ffi_q;
    logic [IW-1:0]     ffi_d;
    logic [COUNT_WIDTH-1:0] scnt_q;
    logic [TW-1:0]     tcnt_q;

    logic [NUM_CHECKS-1:0] en;
    logic [NUM_CHECKS-1:0] pass_d;
    logic [NUM_CHECKS-1:0] fail_d;
    logic [NUM_CHECKS-1:0] miss;
    logic store;
    logic arm_go;
    logic any_fail;
    logic all_pass;
    logic timeout_hit;

    // clear dominates both arm and a concurrent store.
    assign store    = (state_q == MWC_ARMED) && mem_write && !clear;
    assign arm_go   = arm && !clear && (state_q != MWC_ARMED);
    assign any_fail = |fail_d;
    assign all_pass = ((pass_d & en) == en) && !any_fail;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == T_LAST);

    for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_entry
        mwc_entry #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_entry (
            .clk         (clk),
            .reset       (reset),
            .cfg_we_i    (cfg_we && (state_q == MWC_IDLE) && (cfg_idx == IW'(i))),
            .cfg_addr_i  (cfg_addr),
            .cfg_data_i  (cfg_data),
            .cfg_enable_i(cfg_enable),
            .arm_clr_i   (arm_go),
            .store_i     (store),
            .mem_addr_i  (mem_addr),
            .mem_wdata_i (mem_wdata),
            .enable_o    (en[i]),
            .pass_o      (pass_mask[i]),
            .fail_o      (fail_mask[i]),
            .pass_next_o (pass_d[i]),
            .fail_next_o (fail_d[i]),
            .miss_o      (miss[i])
        );
    end

    always_comb begin
        ffi_d = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (miss[i]) ffi_d = IW'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MWC_IDLE;
            timed_out_q <= 1'b0;
            ffi_q       <= '0;
            scnt_q      <= '0;
            tcnt_q      <= '0;
        end else if (clear) begin
            state_q <= MWC_IDLE;
        end else begin
            case (state_q)
                MWC_ARMED: begin
                    tcnt_q <= tcnt_q + TW'(1);
                    if (store && (scnt_q != '1)) scnt_q <= scnt_q + COUNT_WIDTH'(1);
                    // A resolving store outranks a timeout on the same edge.
                    if (any_fail) begin
                        state_q <= MWC_DONE_FAIL;
                        ffi_q   <= ffi_d;
                    end else if (all_pass) begin
                        state_q <= MWC_DONE_PASS;
                    end else if (timeout_hit) begin
                        state_q     <= MWC_DONE_FAIL;
                        timed_out_q <= 1'b1;
                    end
                end
                default: begin
                    if (arm) begin
                        state_q     <= MWC_ARMED;
                        timed_out_q <= 1'b0;
                        ffi_q       <= '0;
                        scnt_q      <= '0;
                        tcnt_q      <= '0;
                    end
                end
            endcase
        end
    end

    assign busy           = (state_q == MWC_ARMED);
    assign success        = (state_q == MWC_DONE_PASS);
    assign fail           = (state_q == MWC_DONE_FAIL);
    assign timed_out      = timed_out_q;
    assign first_fail_idx = ffi_q;
    assign store_count    = scnt_q;

endmodule
